// File: rtl/sfx_pkg.sv
// sfx_pkg: effect IDs, channel masks, durations and FSM states for the sound-effect scheduler
package sfx_pkg;
    localparam int ID_BITS = 2;
    localparam logic [ID_BITS-1:0] ID_BOOM  = 2'd0;
    localparam logic [ID_BITS-1:0] ID_BLIP  = 2'd1;
    localparam logic [ID_BITS-1:0] ID_ZAP   = 2'd2;
    localparam logic [ID_BITS-1:0] ID_HIT   = 2'd3;
    localparam logic [3:0][2:0] CH_MASK = {3'b100, 3'b011, 3'b010, 3'b101};
    localparam logic [3:0][5:0] DUR_TAB = {6'd4, 6'd12, 6'd8, 6'd24};
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;
endpackage

// File: rtl/sfx_prio_enc.sv
// sfx_prio_enc: lowest-index-first priority encoder with one-hot grant
module sfx_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);
    assign valid  = |req;
    assign onehot = req & (~req + N'(1));
    // scan downward so the lowest set index is the last to write
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
    end
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sound-effect scheduler driving APU trigger levels per video frame
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DUR_BITS = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [NUM_REQ-1:0] req,
    output logic               saw_trigger,
    output logic               square_trigger,
    output logic               noise_trigger,
    output logic               busy,
    output logic [1:0]         active_id
);
    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d, grant, act_mask, p_onehot;
    logic [DUR_BITS-1:0]  remain_q, remain_d;
    logic [ID_BITS-1:0]   active_id_q, active_id_d, p_idx;
    logic [2:0]           trig_q, trig_d;
    logic                 busy_q, busy_d, p_valid, frame_tick;

    assign frame_tick = (x == '0) && (y == '0);
    assign act_mask   = (state_q == ST_PLAY) ? (NUM_REQ'(1) << active_id_q) : '0;

    sfx_prio_enc #(.N(NUM_REQ), .W(ID_BITS)) u_enc (
        .req    (pend_q),
        .valid  (p_valid),
        .idx    (p_idx),
        .onehot (p_onehot)
    );

    // next-state: grant from IDLE, preempt/retrigger/expire in PLAY, one silent frame in GAP
    always_comb begin
        grant       = '0;
        state_d     = state_q;
        active_id_d = active_id_q;
        remain_d    = remain_q;
        case (state_q)
            ST_IDLE: if (p_valid) begin
                grant       = p_onehot;
                active_id_d = p_idx;
                remain_d    = DUR_BITS'(DUR_TAB[p_idx]);
                state_d     = ST_PLAY;
            end
            ST_PLAY: if (frame_tick && p_valid && (p_idx < active_id_q)) begin
                grant       = p_onehot;
                active_id_d = p_idx;
                remain_d    = DUR_BITS'(DUR_TAB[p_idx]);
            end else if (req[active_id_q]) begin
                remain_d = DUR_BITS'(DUR_TAB[active_id_q]);
            end else if (frame_tick) begin
                remain_d = remain_q - DUR_BITS'(remain_q != '0);
                state_d  = (remain_q <= DUR_BITS'(1)) ? ST_GAP : ST_PLAY;
            end
            ST_GAP: state_d = frame_tick ? ST_IDLE : ST_GAP;
            default: state_d = ST_IDLE;
        endcase
        pend_d = (pend_q | (req & ~act_mask)) & ~grant;
        trig_d = (state_d == ST_PLAY) ? CH_MASK[active_id_d] : 3'b000;
        busy_d = state_d != ST_IDLE;
    end

    // state and output registers; outputs are registered from next-state so they track the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            remain_q    <= '0;
            active_id_q <= '0;
            trig_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            remain_q    <= remain_d;
            active_id_q <= active_id_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
        end
    end

    assign saw_trigger    = trig_q[0];
    assign square_trigger = trig_q[1];
    assign noise_trigger  = trig_q[2];
    assign busy           = busy_q;
    assign active_id      = active_id_q;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: directed scheduler scenarios with a play-record scoreboard
module tb_sfx_scheduler;
    typedef struct packed {
        logic [1:0] id;
        logic [2:0] mask;
        logic [7:0] ticks;
        logic       gap;
    } play_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic [3:0] req = '0;
    logic       saw_trigger, square_trigger, noise_trigger, busy;
    logic [1:0] active_id;
    int         total = 0;
    int         bad = 0;
    play_t      exp_q[$];
    logic       cur_on = 1'b0;
    logic [1:0] cur_id = '0;
    logic [2:0] cur_mask = '0;
    int         cur_ticks = 0;
    wire  [2:0] trig = {noise_trigger, square_trigger, saw_trigger};

    sfx_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .x              (x),
        .y              (y),
        .req            (req),
        .saw_trigger    (saw_trigger),
        .square_trigger (square_trigger),
        .noise_trigger  (noise_trigger),
        .busy           (busy),
        .active_id      (active_id)
    );

    always #5 clk = ~clk;

    // 4x2 beam raster: frame_tick every 8 cycles
    initial forever begin
        @(posedge clk);
        #2;
        if (x == 10'd3) begin
            x = '0;
            y = (y == 10'd1) ? 10'd0 : y + 10'd1;
        end else x = x + 10'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [2:0] mask, input int ticks, input logic gap);
        play_t p;
        p.id = id;
        p.mask = mask;
        p.ticks = 8'(ticks);
        p.gap = gap;
        exp_q.push_back(p);
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_tick();
        do step(); while (!(x == '0 && y == '0));
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic pulse(input logic [3:0] r);
        req = r;
        step();
        req = '0;
    endtask

    // monitor: build a record per continuous play of one ID and check it against the scoreboard
    always @(negedge clk) begin
        play_t e;
        if (!reset_n) cur_on = 1'b0;
        else begin
            if (cur_on && (trig == 3'b000 || active_id != cur_id)) begin
                chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_id", 32'(cur_id), 32'(e.id));
                    chk("sb_mask", 32'(cur_mask), 32'(e.mask));
                    chk("sb_ticks", 32'(cur_ticks), 32'(e.ticks));
                    chk("sb_gap", 32'(trig == 3'b000), 32'(e.gap));
                end
                cur_on = 1'b0;
            end
            if (trig != 3'b000 && !cur_on) begin
                cur_on = 1'b1;
                cur_id = active_id;
                cur_mask = trig;
                cur_ticks = 0;
            end
            if (cur_on && x == '0 && y == '0) cur_ticks++;
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(active_id), 32'd0);
        reset_n = 1'b1;
        // single request: latency, 8 ticks, one-frame gap
        wait_tick();
        push(2'd1, 3'b010, 8, 1'b1);
        pulse(4'b0010);
        chk("lat_n1_trig", 32'(trig), 32'd0);
        chk("lat_n1_busy", 32'(busy), 32'd0);
        step();
        chk("lat_n2_trig", 32'(trig), 32'b010);
        chk("lat_n2_busy", 32'(busy), 32'd1);
        wait_ticks(8);
        chk("last_tick_trig", 32'(trig), 32'b010);
        step();
        chk("gap_trig", 32'(trig), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        wait_tick();
        chk("gap_end_busy", 32'(busy), 32'd1);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        // priority: two simultaneous requests play in ID order
        wait_tick();
        push(2'd2, 3'b011, 12, 1'b1);
        push(2'd3, 3'b100, 4, 1'b1);
        pulse(4'b1100);
        step();
        chk("prio_first", 32'(active_id), 32'd2);
        wait_ticks(18);
        step();
        chk("prio_idle", 32'(busy), 32'd0);
        // preemption of ID3 by ID0 with no gap
        wait_tick();
        push(2'd3, 3'b100, 2, 1'b0);
        push(2'd0, 3'b101, 24, 1'b1);
        pulse(4'b1000);
        wait_tick();
        step();
        chk("pre_id3", 32'(active_id), 32'd3);
        pulse(4'b0001);
        chk("pre_hold", 32'(active_id), 32'd3);
        wait_tick();
        step();
        chk("pre_id0", 32'(active_id), 32'd0);
        chk("pre_trig", 32'(trig), 32'b101);
        wait_ticks(25);
        step();
        chk("pre_idle", 32'(busy), 32'd0);
        // retrigger on the expiring tick
        wait_tick();
        push(2'd1, 3'b010, 16, 1'b1);
        pulse(4'b0010);
        wait_ticks(8);
        pulse(4'b0010);
        chk("retrig_hold", 32'(trig), 32'b010);
        wait_ticks(9);
        step();
        chk("retrig_idle", 32'(busy), 32'd0);
        // asynchronous reset mid-play drops outputs and pending requests
        wait_tick();
        pulse(4'b0001);
        step();
        step();
        chk("rst_play_trig", 32'(trig), 32'b101);
        pulse(4'b0100);
        reset_n = 1'b0;
        #1;
        chk("rst_async_trig", 32'(trig), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        wait_ticks(3);
        chk("rst_stay_idle", 32'(busy), 32'd0);
        chk("rst_stay_trig", 32'(trig), 32'd0);
        // merge: repeated ID2 requests during ID0 give one ID2 play
        wait_tick();
        push(2'd0, 3'b101, 24, 1'b1);
        push(2'd2, 3'b011, 12, 1'b1);
        pulse(4'b0001);
        step();
        pulse(4'b0100);
        step();
        pulse(4'b0100);
        step();
        pulse(4'b0100);
        wait_ticks(38);
        step();
        step();
        chk("merge_idle", 32'(busy), 32'd0);
        wait_ticks(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("sb_closed", 32'(cur_on), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
